chacha_ks_serializer: RTL and testbench
=======================================

// Module: chacha_ks_serializer
// PURPOSE
//   Keystream sequencer/serializer directly downstream of chacha_core. Takes a
//   message of N 512-bit blocks, drives the core init/next handshake, captures each
//   data_out block and streams it as WORD_W-bit words over valid/ready to the XOR stage.
// PARAMETERS
//   WORD_W   32   output word width; must divide 512 (legal: 32, 64, 128)
//   CNT_W    16   width of num_blocks / internal block counter
// PORTS
//   clk         in   1        single clock, rising edge
//   reset_n     in   1        asynchronous, active-low reset
//   start       in   1        1-cycle pulse: begin message; ignored while busy=1
//   num_blocks  in   CNT_W    block count, sampled on start
//   busy        out  1        high from accepted start until done
//   done        out  1        1-cycle pulse after last word accepted
//   core_init   out  1        1-cycle pulse to chacha_core init
//   core_next   out  1        1-cycle pulse to chacha_core next
//   core_ready  in   1        chacha_core ready
//   core_valid  in   1        chacha_core data_out_valid (level)
//   core_data   in   512      chacha_core data_out
//   out_data    out  WORD_W   keystream word
//   out_valid   out  1        word valid
//   out_ready   in   1        downstream accept; transfer = out_valid & out_ready
//   out_last    out  1        qualifies final word of final block
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, buffer/counters 0; reset mid-message aborts, no done.
// - FSM: IDLE -> START_CORE -> WAIT_BLK -> STREAM -> (REQ_NEXT -> WAIT_BLK | FINISH) -> IDLE.
//   IDLE: start & num_blocks!=0 -> START_CORE, busy=1; start & num_blocks==0 ->
//     done pulse next cycle, no core pulses, busy stays 0.
//   START_CORE: wait core_ready=1, then core_init=1 for exactly one cycle; set pending.
//   WAIT_BLK: capture core_data into 512-bit buffer on pending & core_valid &
//     ~core_valid_q (rising edge only; stale held valid never recaptured); clear pending.
//   STREAM: word index w=0..512/WORD_W-1; out_data = buf[511-w*WORD_W -: WORD_W]
//     (MSB word first); w advances only on transfer; wraps to 0 at block end.
//   REQ_NEXT: entered after last word of non-final block; wait core_ready, pulse core_next 1 cycle.
//   FINISH: done=1 one cycle after final transfer, busy=0 same cycle.
// - out_valid rises the cycle after capture; out_data/out_valid/out_last held stable
//   while out_ready=0. out_last=1 only with the last word of block num_blocks-1.
// - Block counter counts captured blocks; exactly 1 core_init and num_blocks-1
//   core_next per message. core_init and core_next never high together.
// - start while busy: ignored, no state change.
// CONFIGURATION
//   CHACHA_SER_PREFETCH_EN defined: core_next issued (core_ready permitting) the cycle
//     after each non-final capture, so core computes block k+1 while block k streams;
//     at block end, jump straight to WAIT_BLK (capture if edge already seen, via latched
//     edge flag); REQ_NEXT state unused.
//   Undefined: core_next only after last word of a block is accepted (REQ_NEXT path);
//     no overlap, buffer never overwritten while streaming in either mode.
// STRUCTURE
//   chacha_pkg: CHACHA_BLOCK_W=512, CHACHA_KEY_W=256, ser_state_t enum, words-per-block
//     function. No sub-module: FSM + buffer + counters fit in one module.
// TESTING
// - num_blocks=1, WORD_W=32, out_ready=1, core_data=512'h00010203...3f -> 16 words,
//   first 32'h00010203, last 32'h3c3d3e3f with out_last=1, done next cycle, 1 core_init, 0 core_next.
// - num_blocks=0 -> done pulse 1 cycle after start, core_init never asserted, busy stays 0.
// - num_blocks=3 -> 48 transfers, 1 core_init, 2 core_next, out_last only on transfer 48.
// - out_ready low 5 cycles at word 4 -> out_data/out_valid unchanged those cycles; word 5 follows.
// - core_valid held high across core_next -> no recapture until valid drops and rises again.
// - reset_n low at word 7 of block 2 -> all outputs 0 asynchronously; fresh start after
//   release behaves as first test.
// - CHACHA_SER_PREFETCH_EN, core latency 10 cycles, num_blocks=2 -> core_next within
//   1 cycle of block-0 capture; zero idle cycles between word 15 and word 16.

Source files
------------

// File: rtl/chacha_pkg.sv
// Shared ChaCha constants, serializer state encoding and block/word helpers.
package chacha_pkg;

    localparam int unsigned CHACHA_BLOCK_W = 512;
    localparam int unsigned CHACHA_KEY_W   = 256;

    typedef enum logic [2:0] {
        SER_IDLE       = 3'd0,
        SER_START_CORE = 3'd1,
        SER_WAIT_BLK   = 3'd2,
        SER_STREAM     = 3'd3,
        SER_REQ_NEXT   = 3'd4,
        SER_FINISH     = 3'd5
    } ser_state_t;

    function automatic int unsigned words_per_block(input int unsigned word_w);
        return CHACHA_BLOCK_W / word_w;
    endfunction

endpackage

// File: rtl/chacha_ks_serializer.sv
// ChaCha keystream sequencer: drives chacha_core init/next and streams each 512-bit block MSB word first.
// Build option CHACHA_SER_PREFETCH_EN: request block k+1 from the core while block k streams.
module chacha_ks_serializer
    import chacha_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [CNT_W-1:0]          num_blocks,
    output logic                      busy,
    output logic                      done,
    output logic                      core_init,
    output logic                      core_next,
    input  logic                      core_ready,
    input  logic                      core_valid,
    input  logic [CHACHA_BLOCK_W-1:0] core_data,
    output logic [WORD_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last
);

    localparam int unsigned WPB   = words_per_block(WORD_W);
    localparam int unsigned IDX_W = (WPB > 1) ? $clog2(WPB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WPB - 1);

    ser_state_t                state_q, state_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      core_init_q, core_init_d;
    logic                      core_next_q, core_next_d;
    logic [WORD_W-1:0]         out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;
    logic                      out_last_q, out_last_d;
    logic [CHACHA_BLOCK_W-1:0] buf_q, buf_d;
    logic [IDX_W-1:0]          word_q, word_d;
    logic [CNT_W-1:0]          blk_cnt_q, blk_cnt_d;
    logic [CNT_W-1:0]          nblk_q, nblk_d;
    logic                      pending_q, pending_d;
    logic                      edge_seen_q, edge_seen_d;
    logic                      core_valid_q;
`ifdef CHACHA_SER_PREFETCH_EN
    logic                      need_next_q, need_next_d;
`endif

    logic                      core_rise;
    logic                      hit;
    logic                      do_cap;
    logic [CNT_W-1:0]          cnt_inc;
    logic                      cap_final;
    logic                      strm_final;
    logic [IDX_W-1:0]          word_nxt;

    // Word idx of a block, counting from the most significant end.
    function automatic logic [WORD_W-1:0] sel_word(input logic [CHACHA_BLOCK_W-1:0] blk,
                                                   input logic [IDX_W-1:0]          idx);
        logic [CHACHA_BLOCK_W-1:0] sh;
        sh = blk << (32'(idx) * WORD_W);
        return sh[CHACHA_BLOCK_W-1 -: WORD_W];
    endfunction

    // Only a fresh rising edge of core valid after a request counts as a new block.
    assign core_rise  = core_valid & ~core_valid_q;
    assign hit        = pending_q & (core_rise | edge_seen_q);
    assign cnt_inc    = blk_cnt_q + CNT_W'(1);
    assign cap_final  = (cnt_inc == nblk_q);
    assign strm_final = (blk_cnt_q == nblk_q);
    assign word_nxt   = word_q + IDX_W'(1);

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        core_init_d = 1'b0;
        core_next_d = 1'b0;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        buf_d       = buf_q;
        word_d      = word_q;
        blk_cnt_d   = blk_cnt_q;
        nblk_d      = nblk_q;
        pending_d   = pending_q;
        edge_seen_d = edge_seen_q;
        do_cap      = 1'b0;
`ifdef CHACHA_SER_PREFETCH_EN
        need_next_d = need_next_q;
`endif

        if (pending_q && core_rise) edge_seen_d = 1'b1;

        case (state_q)
            SER_IDLE, SER_FINISH: begin
                state_d = SER_IDLE;
                if (start) begin
                    if (num_blocks != '0) begin
                        state_d   = SER_START_CORE;
                        busy_d    = 1'b1;
                        nblk_d    = num_blocks;
                        blk_cnt_d = '0;
                        word_d    = '0;
                    end else begin
                        state_d = SER_FINISH;
                        done_d  = 1'b1;
                    end
                end
            end
            SER_START_CORE: begin
                if (core_ready) begin
                    core_init_d = 1'b1;
                    pending_d   = 1'b1;
                    edge_seen_d = 1'b0;
                    state_d     = SER_WAIT_BLK;
                end
            end
            SER_WAIT_BLK: begin
                if (hit) do_cap = 1'b1;
            end
            SER_STREAM: begin
                if (out_valid_q && out_ready) begin
                    if (word_q == LAST_IDX) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        word_d      = '0;
                        if (strm_final) begin
                            state_d = SER_FINISH;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
`ifdef CHACHA_SER_PREFETCH_EN
                            if (hit) do_cap = 1'b1;
                            else     state_d = SER_WAIT_BLK;
`else
                            state_d = SER_REQ_NEXT;
`endif
                        end
                    end else begin
                        word_d     = word_nxt;
                        out_data_d = sel_word(buf_q, word_nxt);
                        out_last_d = strm_final && (word_nxt == LAST_IDX);
                    end
                end
            end
            SER_REQ_NEXT: begin
                if (core_ready) begin
                    core_next_d = 1'b1;
                    pending_d   = 1'b1;
                    edge_seen_d = 1'b0;
                    state_d     = SER_WAIT_BLK;
                end
            end
            default: state_d = SER_IDLE;
        endcase

        // Block capture: load the buffer and present its first word next cycle.
        if (do_cap) begin
            buf_d       = core_data;
            blk_cnt_d   = cnt_inc;
            pending_d   = 1'b0;
            edge_seen_d = 1'b0;
            state_d     = SER_STREAM;
            word_d      = '0;
            out_valid_d = 1'b1;
            out_data_d  = sel_word(core_data, IDX_W'(0));
            out_last_d  = cap_final && (LAST_IDX == '0);
        end

`ifdef CHACHA_SER_PREFETCH_EN
        if (do_cap && !cap_final) need_next_d = 1'b1;
        if (need_next_d && core_ready) begin
            core_next_d = 1'b1;
            pending_d   = 1'b1;
            edge_seen_d = 1'b0;
            need_next_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= SER_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            core_init_q  <= 1'b0;
            core_next_q  <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            buf_q        <= '0;
            word_q       <= '0;
            blk_cnt_q    <= '0;
            nblk_q       <= '0;
            pending_q    <= 1'b0;
            edge_seen_q  <= 1'b0;
            core_valid_q <= 1'b0;
`ifdef CHACHA_SER_PREFETCH_EN
            need_next_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            core_init_q  <= core_init_d;
            core_next_q  <= core_next_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            buf_q        <= buf_d;
            word_q       <= word_d;
            blk_cnt_q    <= blk_cnt_d;
            nblk_q       <= nblk_d;
            pending_q    <= pending_d;
            edge_seen_q  <= edge_seen_d;
            core_valid_q <= core_valid;
`ifdef CHACHA_SER_PREFETCH_EN
            need_next_q  <= need_next_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign core_init = core_init_q;
    assign core_next = core_next_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_chacha_ks_serializer.sv
// Randomized bench for chacha_ks_serializer: behavioural core stand-in plus a word-queue scoreboard.
module tb_chacha_ks_serializer;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 16;
    localparam int          WPB    = 16;

    logic               clk;
    logic               reset_n;
    logic               start;
    logic [CNT_W-1:0]   num_blocks;
    logic               busy;
    logic               done;
    logic               core_init;
    logic               core_next;
    logic               core_ready;
    logic               core_valid;
    logic [511:0]       core_data;
    logic [WORD_W-1:0]  out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;

    chacha_ks_serializer #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .num_blocks (num_blocks),
        .busy       (busy),
        .done       (done),
        .core_init  (core_init),
        .core_next  (core_next),
        .core_ready (core_ready),
        .core_valid (core_valid),
        .core_data  (core_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned checks = 0;
    int unsigned passed = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Message configuration and scoreboard state
    int msg_nb, lat, hold_len, rmode, crr, fixed_mode, pf_check;
    int n_init, n_next, n_xfer, done_cnt, gen_blk, stall_seen, stall_left;
    int cyc, last_xfer_cyc, done_cyc, prev_xfer_cyc, blk_valid_cyc;
    int lat_cnt, hold_cnt;
    logic        busy_at_done, prev_stall, prev_valid, prev_last, el;
    logic [31:0] prev_data, first_w, last_w, ew;
    logic [511:0] fixed_blk, rblk;
    logic [31:0] exp_q[$];
    logic        last_q[$];

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Core produces a block; the scoreboard expects its words MSB first.
    task automatic gen_block();
        if (fixed_mode != 0) rblk = fixed_blk;
        else for (int i = 0; i < 16; i++) rblk[511-32*i -: 32] = $urandom();
        core_data  = rblk;
        core_valid = 1'b1;
        for (int i = 0; i < WPB; i++) begin
            exp_q.push_back(rblk[511-32*i -: 32]);
            last_q.push_back((gen_blk == msg_nb - 1) && (i == WPB - 1));
        end
        gen_blk++;
    endtask

    // Core model, ready driver and output monitor, all on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            core_valid = 1'b0;
            lat_cnt    = 0;
            hold_cnt   = 0;
            prev_stall = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (prev_stall) begin
                stall_seen++;
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_data", 64'(out_data), 64'(prev_data));
                chk("stall_last", 64'(out_last), 64'(prev_last));
            end
            if (out_valid && !prev_valid) blk_valid_cyc = cyc;
            prev_valid = out_valid;
            if (done) begin
                done_cnt++;
                done_cyc     = cyc;
                busy_at_done = busy;
            end
            if (core_init || core_next) begin
                chk("init_next_excl", 64'(core_init && core_next), 64'd0);
                if (core_init) n_init++;
                if (core_next) begin
                    n_next++;
`ifdef CHACHA_SER_PREFETCH_EN
                    if (pf_check != 0) chk("pf_next_latency", 64'(cyc - blk_valid_cyc <= 1), 64'd1);
`else
                    chk("next_after_last_word", 64'(exp_q.size()), 64'd0);
`endif
                end
                if (hold_len == 0) core_valid = 1'b0;
                else hold_cnt = hold_len;
                lat_cnt = lat;
            end else begin
                if (hold_cnt > 0) begin
                    hold_cnt--;
                    if (hold_cnt == 0) core_valid = 1'b0;
                end
                if (lat_cnt > 0) begin
                    lat_cnt--;
                    if (lat_cnt == 0) gen_block();
                end
            end
            core_ready = (crr != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
            case (rmode)
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (n_xfer == 4 && stall_left > 0) begin
                        out_ready = 1'b0;
                        stall_left--;
                    end else out_ready = 1'b1;
                end
                default: out_ready = 1'b1;
            endcase
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_word", 64'd1, 64'd0);
                else begin
                    ew = exp_q.pop_front();
                    el = last_q.pop_front();
                    chk("word", 64'(out_data), 64'(ew));
                    chk("last", 64'(out_last), 64'(el));
                    if (el) last_xfer_cyc = cyc;
                end
`ifdef CHACHA_SER_PREFETCH_EN
                if (pf_check != 0 && n_xfer == WPB) chk("pf_no_gap", 64'(cyc - prev_xfer_cyc), 64'd1);
`endif
                if (n_xfer == 0) first_w = out_data;
                last_w        = out_data;
                prev_xfer_cyc = cyc;
                n_xfer++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic begin_msg(input int nb, input int l, input int h, input int rm,
                             input int fx, input int cr, input int pf);
        msg_nb = nb; lat = l; hold_len = h; rmode = rm; fixed_mode = fx; crr = cr; pf_check = pf;
        n_init = 0; n_next = 0; n_xfer = 0; done_cnt = 0; gen_blk = 0;
        stall_seen = 0; stall_left = 5; last_xfer_cyc = 0; done_cyc = 0;
        exp_q.delete();
        last_q.delete();
        tick();
        start      = 1'b1;
        num_blocks = CNT_W'(nb);
        tick();
        start = 1'b0;
        if (nb == 0) begin
            chk("zero_done", 64'(done), 64'd1);
            chk("zero_busy", 64'(busy), 64'd0);
        end else begin
            chk("busy_on_start", 64'(busy), 64'd1);
        end
    endtask

    task automatic finish_msg(input int nb);
        if (nb == 0) begin
            repeat (4) tick();
            chk("zero_no_init", 64'(n_init), 64'd0);
            chk("zero_done_pulses", 64'(done_cnt), 64'd1);
            chk("zero_busy_after", 64'(busy), 64'd0);
            return;
        end
        for (int i = 0; i < 3000 && done_cnt == 0; i++) tick();
        if (done_cnt == 0) chk("done_timeout", 64'd0, 64'd1);
        else begin
            chk("done_latency", 64'(done_cyc - last_xfer_cyc), 64'd1);
            chk("busy_at_done", 64'(busy_at_done), 64'd0);
        end
        chk("init_count", 64'(n_init), 64'd1);
        chk("next_count", 64'(n_next), 64'(nb - 1));
        chk("xfer_count", 64'(n_xfer), 64'(nb * WPB));
        chk("leftover_words", 64'(exp_q.size()), 64'd0);
        repeat (3) tick();
        chk("done_pulses", 64'(done_cnt), 64'd1);
        chk("busy_idle", 64'(busy), 64'd0);
    endtask

    task automatic run_msg(input int nb, input int l, input int h, input int rm,
                           input int fx, input int cr, input int pf);
        begin_msg(nb, l, h, rm, fx, cr, pf);
        finish_msg(nb);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_init"}, 64'(core_init), 64'd0);
        chk({tag, "_next"}, 64'(core_next), 64'd0);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_data"}, 64'(out_data), 64'd0);
        chk({tag, "_last"}, 64'(out_last), 64'd0);
    endtask

    initial begin
        int nb, l, h;
        for (int i = 0; i < 64; i++) fixed_blk[511-8*i -: 8] = 8'(i);
        reset_n = 1'b0; start = 1'b0; num_blocks = '0; out_ready = 1'b0;
        core_ready = 1'b1; core_valid = 1'b0; core_data = '0;
        msg_nb = 0; lat = 4; hold_len = 0; rmode = 0; crr = 0; fixed_mode = 0; pf_check = 0;
        cyc = 0; lat_cnt = 0; hold_cnt = 0; prev_stall = 1'b0; prev_valid = 1'b0;
        blk_valid_cyc = 0; prev_xfer_cyc = 0; busy_at_done = 1'b0;
        repeat (3) tick();
        check_idle_outputs("reset");
        reset_n = 1'b1;
        tick();

        // Single fixed block, always-ready sink.
        run_msg(1, 6, 0, 0, 1, 0, 0);
        chk("first_word", 64'(first_w), 64'h00010203);
        chk("final_word", 64'(last_w), 64'h3c3d3e3f);

        run_msg(0, 4, 0, 0, 0, 0, 0);
        run_msg(3, 5, 0, 0, 0, 0, 0);

        // Sink stalls five cycles on word 4.
        run_msg(1, 3, 0, 2, 0, 0, 0);
        chk("stall_cycles", 64'(stall_seen), 64'd5);

        // Core keeps valid asserted for a while after each request.
        run_msg(3, 8, 3, 0, 0, 0, 0);

        // Abort mid-message with an asynchronous reset.
        begin_msg(3, 4, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2000 && n_xfer < 2 * WPB + 7; i++) tick();
        chk("reach_blk2_word7", 64'(n_xfer >= 2 * WPB + 7), 64'd1);
        #2 reset_n = 1'b0;
        #1 check_idle_outputs("abort");
        repeat (3) tick();
        chk("no_done_after_abort", 64'(done_cnt), 64'd0);
        reset_n = 1'b1;
        tick();
        run_msg(1, 6, 0, 0, 1, 0, 0);
        chk("first_word_after_reset", 64'(first_w), 64'h00010203);

        // Two blocks with a 10-cycle core latency.
        run_msg(2, 10, 0, 0, 0, 0, 1);

        for (int k = 0; k < 8; k++) begin
            nb = int'($urandom_range(1, 4));
            l  = int'($urandom_range(2, 20));
            h  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, l - 1)) : 0;
            run_msg(nb, l, h, 1, 0, int'($urandom_range(0, 1)), 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
